// File: rtl/uart_frame_accumulator.sv
// Collects strobed UART bytes into a frame buffer and delivers frames on CR or 0xBE 0xEF termination.
// Optional build macro UART_ACC_CHECKSUM_EN: last stored byte is an XOR checksum, verified and stripped.
module uart_frame_accumulator #(
    parameter int unsigned  MAX_BYTES = 128,
    parameter int unsigned  TIMEOUT   = 2000,
    parameter logic [7:0]   TERM_CR   = 8'h0D,
    parameter logic [7:0]   TERM_HI   = 8'hBE,
    parameter logic [7:0]   TERM_LO   = 8'hEF,
    localparam int unsigned SIZE_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   mode,
    input  logic                   soft_clear,
    output logic [8*MAX_BYTES-1:0] out_data,
    output logic [SIZE_W-1:0]      out_size,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   error,
    output logic [2:0]             error_code
);

    localparam int unsigned BUF_W  = 8 * MAX_BYTES;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW = 3'd2;
    localparam logic [2:0] ERR_BAD_TERM = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_TERM2   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_in_valid_d;
    logic [BUF_W-1:0]    r_buf;
    logic [SIZE_W-1:0]   r_count;
    logic                r_mode;
    logic [IDLE_W-1:0]   r_idle_cnt;

    logic                w_accept;
    logic                w_term_in;
    logic                w_term_frame;
    logic                w_timeout;
    logic                w_store;
    logic                w_start;
    logic                w_finish;
    logic                w_complete;
    logic                w_fault;
    logic [2:0]          w_fault_code;
    logic                w_csum_ok;
    logic [BUF_W-1:0]    w_frame_data;
    logic [SIZE_W-1:0]   w_frame_size;

    assign w_accept     = in_valid & ~r_in_valid_d;
    assign w_term_in    = mode   ? (in_data == TERM_CR) : (in_data == TERM_HI);
    assign w_term_frame = r_mode ? (in_data == TERM_CR) : (in_data == TERM_HI);
    assign w_timeout    = (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

`ifdef UART_ACC_CHECKSUM_EN
    logic [7:0] r_xor;

    assign w_csum_ok = (r_xor == 8'h00);

    // Delivered frame drops the trailing checksum byte.
    always_comb begin
        w_frame_data = r_buf;
        w_frame_size = r_count - SIZE_W'(1);
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (r_count == SIZE_W'(i + 1)) begin
                w_frame_data[8*i +: 8] = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_xor <= 8'h00;
        end else if (soft_clear || w_complete || w_fault) begin
            r_xor <= 8'h00;
        end else if (w_store) begin
            r_xor <= r_xor ^ in_data;
        end
    end
`else
    assign w_csum_ok = 1'b1;

    always_comb begin
        w_frame_data = r_buf;
        w_frame_size = r_count;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-edge action decode; soft_clear overrides any byte or timeout.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_store      = 1'b0;
        w_finish     = 1'b0;
        w_complete   = 1'b0;
        w_fault      = 1'b0;
        w_fault_code = ERR_NONE;

        if (soft_clear) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !w_term_in) begin
                        w_start      = 1'b1;
                        w_store      = 1'b1;
                        w_state_next = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        if (w_term_frame) begin
                            if (r_mode) begin
                                w_finish = 1'b1;
                            end else begin
                                w_state_next = S_TERM2;
                            end
                        end else if (r_count < SIZE_W'(MAX_BYTES)) begin
                            w_store = 1'b1;
                        end else begin
                            w_fault      = 1'b1;
                            w_fault_code = ERR_OVERFLOW;
                        end
                    end else if (w_timeout) begin
                        w_fault      = 1'b1;
                        w_fault_code = ERR_TIMEOUT;
                    end
                end
                S_TERM2: begin
                    if (w_accept) begin
                        if (in_data == TERM_LO) begin
                            w_finish = 1'b1;
                        end else begin
                            w_fault      = 1'b1;
                            w_fault_code = ERR_BAD_TERM;
                        end
                    end else if (w_timeout) begin
                        w_fault      = 1'b1;
                        w_fault_code = ERR_TIMEOUT;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase

            if (w_finish) begin
                if (w_csum_ok) begin
                    w_complete = 1'b1;
                end else begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_CHECKSUM;
                end
            end
            if (w_finish || w_fault) begin
                w_state_next = S_IDLE;
            end
        end
    end

    // Frame buffer, idle timer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_valid_d <= 1'b0;
            r_buf        <= '0;
            r_count      <= '0;
            r_mode       <= 1'b0;
            r_idle_cnt   <= '0;
            out_data     <= '0;
            out_size     <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            error_code   <= ERR_NONE;
        end else begin
            r_in_valid_d <= in_valid;
            out_valid    <= 1'b0;
            error        <= 1'b0;
            busy         <= (w_state_next != S_IDLE);

            if (r_state == S_IDLE || w_accept) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end

            if (soft_clear) begin
                r_buf      <= '0;
                r_count    <= '0;
                error_code <= ERR_NONE;
            end else begin
                if (w_start) begin
                    r_mode     <= mode;
                    error_code <= ERR_NONE;
                end
                if (w_store) begin
                    for (int i = 0; i < MAX_BYTES; i++) begin
                        if (r_count == SIZE_W'(i)) begin
                            r_buf[8*i +: 8] <= in_data;
                        end
                    end
                    r_count <= r_count + SIZE_W'(1);
                end
                if (w_complete) begin
                    out_data  <= w_frame_data;
                    out_size  <= w_frame_size;
                    out_valid <= 1'b1;
                end
                if (w_complete || w_fault) begin
                    r_buf   <= '0;
                    r_count <= '0;
                end
                if (w_fault) begin
                    error      <= 1'b1;
                    error_code <= w_fault_code;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_accumulator.sv
// Directed bench for uart_frame_accumulator with MAX_BYTES=4 and TIMEOUT=100.
module tb_uart_frame_accumulator;

    localparam int unsigned MAXB = 4;
    localparam int unsigned TMO  = 100;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [7:0]          in_data = 8'h00;
    logic                in_valid = 1'b0;
    logic                mode = 1'b1;
    logic                soft_clear = 1'b0;
    logic [8*MAXB-1:0]   out_data;
    logic [2:0]          out_size;
    logic                out_valid;
    logic                busy;
    logic                error;
    logic [2:0]          error_code;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int nv;
    int ne;

    uart_frame_accumulator #(.MAX_BYTES(MAXB), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .mode(mode), .soft_clear(soft_clear), .out_data(out_data), .out_size(out_size),
        .out_valid(out_valid), .busy(busy), .error(error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid) n_valid++;
        if (error) n_err++;
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic strobe(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        gap(2);
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        checks++; if (out_size !== 3'd0) begin errors++; $display("FAIL reset_out_size: got %0d expected 0", out_size); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        checks++; if (error_code !== 3'd0) begin errors++; $display("FAIL reset_error_code: got %0d expected 0", error_code); end
        reset_n = 1'b1;
        gap(1);
    endtask

    task automatic test_mode1;
        mode = 1'b1;
        nv = n_valid; ne = n_err;
        strobe(8'h41);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mode1_busy: got %b expected 1", busy); end
        gap(8); strobe(8'h54); gap(8); strobe(8'h0D);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode1_valid: got %b expected 1", out_valid); end
        checks++; if (out_size !== 3'd2) begin errors++; $display("FAIL mode1_size: got %0d expected 2", out_size); end
        checks++; if (out_data !== 32'h0000_5441) begin errors++; $display("FAIL mode1_data: got %h expected 00005441", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mode1_busy_end: got %b expected 0", busy); end
        gap(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode1_valid_pulse: got %b expected 0", out_valid); end
        gap(2);
        checks++; if (n_valid - nv !== 1) begin errors++; $display("FAIL mode1_valid_count: got %0d expected 1", n_valid - nv); end
        checks++; if (n_err - ne !== 0) begin errors++; $display("FAIL mode1_err_count: got %0d expected 0", n_err - ne); end
    endtask

    task automatic test_mode0;
        mode = 1'b0;
        strobe(8'h01); gap(2); strobe(8'h02); gap(2); strobe(8'hBE);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mode0_term2_busy: got %b expected 1", busy); end
        gap(2); strobe(8'hEF);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode0_valid: got %b expected 1", out_valid); end
        checks++; if (out_size !== 3'd2) begin errors++; $display("FAIL mode0_size: got %0d expected 2", out_size); end
        checks++; if (out_data !== 32'h0000_0201) begin errors++; $display("FAIL mode0_data: got %h expected 00000201", out_data); end
        gap(2);
        strobe(8'h01); gap(2); strobe(8'hBE); gap(2); strobe(8'h55);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL badterm_error: got %b expected 1", error); end
        checks++; if (error_code !== 3'd3) begin errors++; $display("FAIL badterm_code: got %0d expected 3", error_code); end
        checks++; if (out_data !== 32'h0000_0201) begin errors++; $display("FAIL badterm_data_kept: got %h expected 00000201", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL badterm_valid: got %b expected 0", out_valid); end
        gap(1);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL badterm_error_pulse: got %b expected 0", error); end
        checks++; if (error_code !== 3'd3) begin errors++; $display("FAIL badterm_code_hold: got %0d expected 3", error_code); end
    endtask

    task automatic test_overflow;
        logic [7:0] b;
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'h10 + 8'(i);
            strobe(b);
            gap(1);
        end
        checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL ovf_full: got busy=%b error=%b expected busy=1 error=0", busy, error); end
        strobe(8'h14);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b expected 1", error); end
        checks++; if (error_code !== 3'd2) begin errors++; $display("FAIL ovf_code: got %0d expected 2", error_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy: got %b expected 0", busy); end
        gap(2);
        nv = n_valid;
        strobe(8'h0D);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL ovf_cr_discard: got busy=%b valid=%b expected 0 0", busy, out_valid); end
        gap(2);
        checks++; if (n_valid !== nv) begin errors++; $display("FAIL ovf_cr_valid_count: got %0d expected %0d", n_valid, nv); end
        checks++; if (out_size !== 3'd2) begin errors++; $display("FAIL ovf_size_kept: got %0d expected 2", out_size); end
    endtask

    task automatic test_timeout;
        mode = 1'b1;
        strobe(8'h31);
        gap(TMO - 1);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early: got error=%b busy=%b expected 0 1", error, busy); end
        gap(1);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b expected 1", error); end
        checks++; if (error_code !== 3'd1) begin errors++; $display("FAIL tmo_code: got %0d expected 1", error_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", busy); end
        gap(2);
        in_data = 8'h41;
        in_valid = 1'b1;
        gap(50);
        in_valid = 1'b0;
        gap(1);
        checks++; if (busy !== 1'b1 || error_code !== 3'd0) begin errors++; $display("FAIL hold_start: got busy=%b code=%0d expected 1 0", busy, error_code); end
        strobe(8'h0D);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", out_valid); end
        checks++; if (out_size !== 3'd1) begin errors++; $display("FAIL hold_size: got %0d expected 1", out_size); end
        checks++; if (out_data !== 32'h0000_0041) begin errors++; $display("FAIL hold_data: got %h expected 00000041", out_data); end
        gap(2);
    endtask

    task automatic test_timeout_edge;
        mode = 1'b1;
        strobe(8'h61);
        gap(TMO - 1);
        strobe(8'h62);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_edge_byte_wins: got error=%b busy=%b expected 0 1", error, busy); end
        gap(2);
        strobe(8'h0D);
        checks++; if (out_size !== 3'd2 || out_data !== 32'h0000_6261) begin errors++; $display("FAIL tmo_edge_frame: got size=%0d data=%h expected 2 00006261", out_size, out_data); end
        gap(2);
    endtask

    task automatic test_back_to_back;
        mode = 1'b1;
        strobe(8'h55); gap(1); strobe(8'h0D);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0055) begin errors++; $display("FAIL b2b_first: got valid=%b data=%h expected 1 00000055", out_valid, out_data); end
        gap(1);
        strobe(8'h66);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
        gap(1); strobe(8'h0D);
        checks++; if (out_size !== 3'd1 || out_data !== 32'h0000_0066) begin errors++; $display("FAIL b2b_second: got size=%0d data=%h expected 1 00000066", out_size, out_data); end
        gap(2);
    endtask

    task automatic test_soft_clear;
        mode = 1'b1;
        nv = n_valid;
        strobe(8'h41); gap(2);
        soft_clear = 1'b1;
        in_data = 8'h42;
        in_valid = 1'b1;
        @(negedge clk);
        soft_clear = 1'b0;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sclr_busy: got %b expected 0", busy); end
        checks++; if (error_code !== 3'd0 || error !== 1'b0) begin errors++; $display("FAIL sclr_error: got code=%0d error=%b expected 0 0", error_code, error); end
        checks++; if (out_size !== 3'd1 || out_data !== 32'h0000_0066) begin errors++; $display("FAIL sclr_kept: got size=%0d data=%h expected 1 00000066", out_size, out_data); end
        gap(2);
        strobe(8'h0D);
        gap(2);
        checks++; if (n_valid !== nv) begin errors++; $display("FAIL sclr_no_valid: got %0d expected %0d", n_valid, nv); end
    endtask

    task automatic test_reset_mid;
        strobe(8'h41); gap(2);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (out_size !== 3'd0 || out_data !== 32'h0) begin errors++; $display("FAIL rstmid_out: got size=%0d data=%h expected 0 0", out_size, out_data); end
        @(negedge clk);
        reset_n = 1'b1;
        gap(1);
    endtask

    task automatic test_checksum;
        mode = 1'b1;
        strobe(8'h12); gap(2); strobe(8'h34); gap(2); strobe(8'h26); gap(2); strobe(8'h0D);
`ifdef UART_ACC_CHECKSUM_EN
        checks++; if (out_valid !== 1'b1 || out_size !== 3'd2) begin errors++; $display("FAIL csum_ok: got valid=%b size=%0d expected 1 2", out_valid, out_size); end
        checks++; if (out_data !== 32'h0000_3412) begin errors++; $display("FAIL csum_data: got %h expected 00003412", out_data); end
`else
        checks++; if (out_valid !== 1'b1 || out_size !== 3'd3) begin errors++; $display("FAIL plain3_ok: got valid=%b size=%0d expected 1 3", out_valid, out_size); end
        checks++; if (out_data !== 32'h0026_3412) begin errors++; $display("FAIL plain3_data: got %h expected 00263412", out_data); end
`endif
        gap(2);
        strobe(8'h12); gap(2); strobe(8'h34); gap(2); strobe(8'h27); gap(2); strobe(8'h0D);
`ifdef UART_ACC_CHECKSUM_EN
        checks++; if (error !== 1'b1 || error_code !== 3'd4) begin errors++; $display("FAIL csum_bad: got error=%b code=%0d expected 1 4", error, error_code); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL csum_bad_valid: got %b expected 0", out_valid); end
`else
        checks++; if (error !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL plain3b_flags: got error=%b valid=%b expected 0 1", error, out_valid); end
        checks++; if (out_data !== 32'h0027_3412) begin errors++; $display("FAIL plain3b_data: got %h expected 00273412", out_data); end
`endif
        gap(2);
    endtask

    initial begin
        test_reset;
        test_mode1;
        test_mode0;
        test_overflow;
        test_timeout;
        test_timeout_edge;
        test_back_to_back;
        test_soft_clear;
        test_reset_mid;
        test_checksum;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
